// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART transmit feeder: byte width, defaults,
// sequencer state encodings and a saturating increment helper.
package uart_defs_pkg;

    localparam int UART_BYTE_W          = 8;
    localparam int DEFAULT_DEPTH_LOG2   = 4;
    localparam int DEFAULT_BUSY_TIMEOUT = 1023;
    localparam int TMO_W                = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_REQ  = 2'd2,
        ST_WAIT = 2'd3
    } txState_t;

    // Busy-wait counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [TMO_W-1:0] satInc(input logic [TMO_W-1:0] value);
        return (value == {TMO_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Register-based byte FIFO with natural-wrap pointers and a separate
// occupancy counter; pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_wrData,
    output logic [WIDTH-1:0]      o_rdData,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_doPush;
    logic w_doPop;

    assign w_full   = (r_count == FULL_COUNT);
    assign w_empty  = (r_count == '0);
    assign w_doPush = i_push & ~w_full;
    assign w_doPop  = i_pop & ~w_empty;

    assign o_rdData = r_mem[r_rdPtr];
    assign o_count  = r_count;
    assign o_full   = w_full;
    assign o_empty  = w_empty;

    // Storage array is written on accepted pushes only and is never reset.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    // Pointers advance on their own operation; count moves only when exactly one happens.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer that drives the UART_Sender Tx_Data/Tx_Send/Tx_Busy
// handshake, delivering each queued byte exactly once or dropping it on a busy timeout.
module uart_tx_feeder
    import uart_defs_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                    Clk_100M,
    input  logic                    Reset,
    input  logic [UART_BYTE_W-1:0]  In_Data,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    output logic [UART_BYTE_W-1:0]  Tx_Data,
    output logic                    Tx_Send,
    input  logic                    Tx_Busy,
    output logic [DEPTH_LOG2:0]     Count,
    output logic                    Empty,
    output logic                    Full,
    output logic                    Timeout
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(BUSY_TIMEOUT);

    txState_t               r_state;
    logic [UART_BYTE_W-1:0] r_txData;
    logic                   r_txSend;
    logic                   r_timeout;
    logic [TMO_W-1:0]       r_tmo;

    txState_t               w_stateNext;
    logic [UART_BYTE_W-1:0] w_txDataNext;
    logic                   w_txSendNext;
    logic                   w_timeoutNext;
    logic [TMO_W-1:0]       w_tmoNext;
    logic [TMO_W-1:0]       w_tmoInc;
    logic                   w_pop;
    logic [UART_BYTE_W-1:0] w_fifoData;
    logic                   w_full;
    logic                   w_empty;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (UART_BYTE_W)
    ) u_fifo (
        .i_clk    (Clk_100M),
        .i_rst    (Reset),
        .i_push   (In_Valid),
        .i_pop    (w_pop),
        .i_wrData (In_Data),
        .o_rdData (w_fifoData),
        .o_count  (Count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign In_Ready = ~w_full;
    assign Full     = w_full;
    assign Empty    = w_empty;
    assign Tx_Data  = r_txData;
    assign Tx_Send  = r_txSend;
    assign Timeout  = r_timeout;
    assign w_tmoInc = satInc(r_tmo);

    // Sequencer registers; every output toward the sender comes straight from a flop.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_txData  <= '0;
            r_txSend  <= 1'b0;
            r_timeout <= 1'b0;
            r_tmo     <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_txData  <= w_txDataNext;
            r_txSend  <= w_txSendNext;
            r_timeout <= w_timeoutNext;
            r_tmo     <= w_tmoNext;
        end
    end

    // Next-state logic: pop into Tx_Data, raise Tx_Send a cycle later, then wait out the frame.
    always_comb begin
        w_stateNext   = r_state;
        w_txDataNext  = r_txData;
        w_txSendNext  = r_txSend;
        w_timeoutNext = r_timeout;
        w_tmoNext     = r_tmo;
        w_pop         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !Tx_Busy) begin
                    w_pop        = 1'b1;
                    w_txDataNext = w_fifoData;
                    w_stateNext  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_txSendNext = 1'b1;
                w_tmoNext    = '0;
                w_stateNext  = ST_REQ;
            end
            ST_REQ: begin
                if (Tx_Busy) begin
                    w_txSendNext = 1'b0;
                    w_stateNext  = ST_WAIT;
                end else begin
                    w_tmoNext = w_tmoInc;
                    if (w_tmoInc == TMO_LIMIT) begin
                        w_txSendNext  = 1'b0;
                        w_timeoutNext = 1'b1;
                        w_stateNext   = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (!Tx_Busy) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a behavioural UART_Sender model
// and a queue-based reference of which bytes must appear on the wire, in order.
module tb_uart_tx_feeder;

    localparam int PERIOD       = 10;
    localparam int BUSY_DELAY   = 2;
    localparam int BUSY_LEN     = 20;
    localparam int BUSY_TIMEOUT = 1023;

    logic       Clk_100M;
    logic       Reset;
    logic [7:0] In_Data;
    logic       In_Valid;
    logic       In_Ready;
    logic [7:0] Tx_Data;
    logic       Tx_Send;
    logic       Tx_Busy;
    logic [4:0] Count;
    logic       Empty;
    logic       Full;
    logic       Timeout;

    int         checkCount = 0;
    int         passCount  = 0;

    logic [7:0] sentQ[$];
    logic [7:0] expQ[$];
    logic       senderOn     = 1'b1;
    logic       modelBusy    = 1'b0;
    logic       forceBusy    = 1'b0;
    logic       frameAborted = 1'b0;
    logic       fallSeen     = 1'b0;
    time        lastFall     = 0;

    assign Tx_Busy = modelBusy | forceBusy;

    uart_tx_feeder dut (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .In_Data  (In_Data),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Tx_Data  (Tx_Data),
        .Tx_Send  (Tx_Send),
        .Tx_Busy  (Tx_Busy),
        .Count    (Count),
        .Empty    (Empty),
        .Full     (Full),
        .Timeout  (Timeout)
    );

    initial begin
        Clk_100M = 1'b0;
        forever #(PERIOD/2) Clk_100M = ~Clk_100M;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Sender model: record every Tx_Send rise; if enabled, answer with Tx_Busy 2 cycles later for 20 cycles.
    initial begin : senderModel
        logic       prevSend;
        logic [7:0] latched;
        prevSend = 1'b0;
        forever begin
            @(negedge Clk_100M);
            if (Tx_Send && !prevSend) begin
                sentQ.push_back(Tx_Data);
                if (fallSeen) checkOutput("sendGap", 32'(($time - lastFall) >= 2*PERIOD), 1);
                if (senderOn) begin
                    latched      = Tx_Data;
                    frameAborted = 1'b0;
                    repeat (BUSY_DELAY) @(negedge Clk_100M);
                    modelBusy = 1'b1;
                    repeat (BUSY_LEN-1) @(negedge Clk_100M);
                    if (!frameAborted) checkOutput("dataStable", Tx_Data, latched);
                    @(negedge Clk_100M);
                    modelBusy = 1'b0;
                    lastFall  = $time;
                    fallSeen  = 1'b1;
                end
            end
            prevSend = Tx_Send;
        end
    end

    // Single-cycle push of a byte known to fit; called on a falling edge.
    task automatic applyStimulus(input logic [7:0] b);
        In_Data  = b;
        In_Valid = 1'b1;
        expQ.push_back(b);
        @(negedge Clk_100M);
        In_Valid = 1'b0;
    endtask

    // Producer honouring In_Ready: hold the byte until it is accepted.
    task automatic pushWait(input logic [7:0] b);
        logic accepted;
        accepted = 1'b0;
        In_Data  = b;
        In_Valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (In_Ready) begin
                @(negedge Clk_100M);
                accepted = 1'b1;
                break;
            end
            @(negedge Clk_100M);
        end
        In_Valid = 1'b0;
        if (accepted) expQ.push_back(b);
        checkOutput("pushAccepted", 32'(accepted), 1);
    endtask

    // Wait for n frames to finish, then compare the wire sequence with the reference queue.
    task automatic waitDone(input int n);
        int budget;
        budget = 0;
        while (!(sentQ.size() >= n && !Tx_Busy && !Tx_Send) && budget < 8000) begin
            @(negedge Clk_100M);
            budget++;
        end
        repeat (6) @(negedge Clk_100M);
        checkOutput("frameCount", 32'(sentQ.size()), 32'(n));
        for (int i = 0; i < n && sentQ.size() > 0 && expQ.size() > 0; i++) begin
            checkOutput($sformatf("frame%0d", i), 32'(sentQ.pop_front()), 32'(expQ.pop_front()));
        end
        sentQ.delete();
        expQ.delete();
    endtask

    initial begin : stimulus
        logic [7:0] b;
        int         waitCycles;
        int         highCycles;

        Reset    = 1'b1;
        In_Valid = 1'b0;
        In_Data  = 8'h00;
        repeat (3) @(negedge Clk_100M);
        checkOutput("rstTxData", Tx_Data, 0);
        checkOutput("rstTxSend", Tx_Send, 0);
        checkOutput("rstCount", Count, 0);
        checkOutput("rstEmpty", Empty, 1);
        checkOutput("rstFull", Full, 0);
        checkOutput("rstTimeout", Timeout, 0);
        checkOutput("rstInReady", In_Ready, 1);
        Reset = 1'b0;
        @(negedge Clk_100M);

        $display("[TB] single byte latency");
        applyStimulus(8'h41);
        checkOutput("latCount", Count, 1);
        checkOutput("latSend1", Tx_Send, 0);
        @(negedge Clk_100M);
        checkOutput("latSend2", Tx_Send, 0);
        @(negedge Clk_100M);
        checkOutput("latSend3", Tx_Send, 1);
        checkOutput("latData", Tx_Data, 8'h41);
        waitDone(1);
        checkOutput("singleEmpty", Empty, 1);

        $display("[TB] burst to full, overflow drop, concurrent push/pop");
        forceBusy = 1'b1;
        @(negedge Clk_100M);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checkOutput("burstCount15", Count, 15);
                checkOutput("burstNotFull", Full, 0);
            end
            In_Data  = 8'(i);
            In_Valid = 1'b1;
            expQ.push_back(8'(i));
            @(negedge Clk_100M);
        end
        In_Valid = 1'b0;
        checkOutput("burstFull", Full, 1);
        checkOutput("burstReady", In_Ready, 0);
        checkOutput("burstCount", Count, 16);
        In_Data  = 8'hEE;
        In_Valid = 1'b1;
        @(negedge Clk_100M);
        In_Valid = 1'b0;
        checkOutput("dropCount", Count, 16);
        forceBusy = 1'b0;
        pushWait(8'hAA);
        checkOutput("concCount", Count, 16);
        checkOutput("concFull", Full, 1);
        waitDone(17);
        checkOutput("burstEmpty", Empty, 1);

        $display("[TB] busy timeout");
        senderOn = 1'b0;
        applyStimulus(8'h55);
        waitCycles = 0;
        while (!Tx_Send && waitCycles < 20) begin
            @(negedge Clk_100M);
            waitCycles++;
        end
        highCycles = 0;
        while (Tx_Send && highCycles < 2000) begin
            @(negedge Clk_100M);
            highCycles++;
        end
        checkOutput("tmoSendCycles", 32'(highCycles), BUSY_TIMEOUT);
        checkOutput("tmoFlag", Timeout, 1);
        senderOn = 1'b1;
        applyStimulus(8'h66);
        waitDone(2);
        checkOutput("tmoSticky", Timeout, 1);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 6; i++) begin
            b        = 8'($urandom_range(0, 255));
            In_Data  = b;
            In_Valid = 1'b1;
            expQ.push_back(b);
            @(negedge Clk_100M);
        end
        In_Valid = 1'b0;
        waitCycles = 0;
        while (!modelBusy && waitCycles < 50) begin
            @(negedge Clk_100M);
            waitCycles++;
        end
        @(negedge Clk_100M);
        checkOutput("midCount", Count, 5);
        frameAborted = 1'b1;
        Reset        = 1'b1;
        @(negedge Clk_100M);
        checkOutput("midRstCount", Count, 0);
        checkOutput("midRstEmpty", Empty, 1);
        checkOutput("midRstSend", Tx_Send, 0);
        checkOutput("midRstTimeout", Timeout, 0);
        checkOutput("midRstData", Tx_Data, 0);
        Reset = 1'b0;
        while (expQ.size() > 1) void'(expQ.pop_back());
        waitDone(1);
        applyStimulus(8'h3C);
        checkOutput("postRstSend1", Tx_Send, 0);
        @(negedge Clk_100M);
        checkOutput("postRstSend2", Tx_Send, 0);
        @(negedge Clk_100M);
        checkOutput("postRstSend3", Tx_Send, 1);
        checkOutput("postRstData", Tx_Data, 8'h3C);
        waitDone(1);

        $display("[TB] busy while idle");
        forceBusy = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(0, 255)));
        repeat (10) @(negedge Clk_100M);
        checkOutput("busyIdleNoSend", 32'(sentQ.size()), 0);
        checkOutput("busyIdleSend", Tx_Send, 0);
        checkOutput("busyIdleCount", Count, 3);
        forceBusy = 1'b0;
        waitDone(3);

        $display("[TB] random traffic with back-pressure");
        for (int k = 0; k < 24; k++) begin
            pushWait(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) @(negedge Clk_100M);
        end
        waitDone(24);
        checkOutput("randEmpty", Empty, 1);
        checkOutput("randCount", Count, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
